// File: rtl/dff_share_arbiter_pkg.sv
// Shared types and width helpers for the shared-register arbiters.
package dff_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int h);
    return (h > 1) ? $clog2(h + 1) : 1;
  endfunction

endpackage

// File: rtl/dff_share_arbiter_if.sv
// Requester-side bus of the shared register: request/data in, grant/ack/register out.
interface dff_share_arbiter_if
  import dff_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) ();
  localparam int IDX_W = idx_w(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] din;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       q;
  logic [IDX_W-1:0]       q_owner;
  logic                   q_valid;

  modport master (output req, din, input gnt, ack, q, q_owner, q_valid);
  modport slave  (input req, din, output gnt, ack, q, q_owner, q_valid);
endinterface

// File: rtl/dff_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);
  logic [IDX_W-1:0] cand;

  // Walk from farthest to nearest so the closest candidate to ptr wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr_i) + k) % N_REQ);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end
endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin owner of one shared WIDTH-bit register: grant, load, hold, re-arbitrate.
module dff_share_arbiter
  import dff_share_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input logic                clk,
  input logic                rst,
  dff_share_arbiter_if.slave bus
);
  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = cnt_w(HOLD_CYCLES);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qv_q, qv_d;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    qv_d    = qv_q;
    gnt_d   = '0;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          state_d = LOAD;
          for (int i = 0; i < N_REQ; i++)
            if (IDX_W'(i) == pick_idx) gnt_d[i] = 1'b1;
        end
      end
      LOAD: begin
        // Grant is committed: load din[sel] whether or not req[sel] is still up.
        for (int i = 0; i < N_REQ; i++) begin
          if (IDX_W'(i) == sel_q) begin
            q_d      = bus.din[i*WIDTH +: WIDTH];
            ack_d[i] = 1'b1;
          end
        end
        owner_d = sel_q;
        qv_d    = 1'b1;
        ptr_d   = (sel_q == IDX_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
        if (HOLD_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_q;
  assign bus.q       = q_q;
  assign bus.q_owner = owner_q;
  assign bus.q_valid = qv_q;
endmodule

// File: tb/tb_dff_share_arbiter.sv
// Two arbiters (hold 2 and hold 0) on one clock, each with a schedule-level model and scoreboard.
module tb_dff_share_arbiter;
  typedef enum int {M_RAND, M_SINGLE, M_ALL, M_WRAP, M_COMMIT, M_0011} mode_e;
  typedef struct {int idx; logic [7:0] data;} exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  mode_e mode = M_RAND;
  int    n_pass = 0;
  int    n_total = 0;
  logic [3:0] gnt_w [2];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s u%0d t=%0t got %0h expected %0h", nm, u, $time, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int H = (g == 0) ? 2 : 0;

    dff_share_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();
    dff_share_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYCLES(H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign gnt_w[g] = bus.gnt;

    // Requester agents: inputs change only on the falling edge.
    logic [3:0] pend = '0;
    bit         seen = 1'b0;
    always @(negedge clk) begin
      if (rst) begin
        pend = '0;
        seen = 1'b0;
      end
      case (mode)
        M_RAND: begin
          for (int i = 0; i < 4; i++) begin
            if (bus.ack[i]) pend[i] = 1'b0;
            if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
            else if (!pend[i] && !bus.gnt[i] && $urandom_range(0, 2) == 0) begin
              pend[i] = 1'b1;
              bus.din[i*8 +: 8] = 8'($urandom);
            end
          end
          bus.req = pend;
        end
        M_SINGLE: begin
          bus.din[23:16] = 8'hA5;
          if (bus.ack[2]) seen = 1'b1;
          bus.req = seen ? 4'b0000 : 4'b0100;
        end
        M_COMMIT: begin
          bus.din[15:8] = 8'h3C;
          if (bus.gnt[1]) seen = 1'b1;
          bus.req = seen ? 4'b0000 : 4'b0010;
        end
        default: begin
          for (int i = 0; i < 4; i++) bus.din[i*8 +: 8] = 8'(8'h10 + i);
          bus.req = (mode == M_ALL) ? 4'b1111 : (mode == M_WRAP) ? 4'b1001 : 4'b0011;
        end
      endcase
    end

    // Reference: arbitration opportunities every H+2 edges after a pick, else every edge.
    exp_t       sbq[$];
    int         cyc = 0, next_arb = 0, ptr = 0, win = 0;
    bit         lpend = 1'b0, m_rst = 1'b1;
    logic [3:0] exp_gnt = '0;
    logic [7:0] exp_q = '0;
    logic [1:0] exp_own = '0;
    logic       exp_qv = 1'b0;
    always @(posedge clk) begin
      exp_t e;
      cyc++;
      if (rst) begin
        ptr = 0; lpend = 1'b0; next_arb = cyc + 1; m_rst = 1'b1;
        exp_gnt = '0; exp_q = '0; exp_own = '0; exp_qv = 1'b0;
        sbq.delete();
      end else begin
        m_rst = 1'b0;
        exp_gnt = '0;
        if (lpend) begin
          e.idx = win; e.data = bus.din[win*8 +: 8];
          sbq.push_back(e);
          exp_q = e.data; exp_own = 2'(win); exp_qv = 1'b1;
          ptr = (win + 1) % 4; lpend = 1'b0;
        end
        if (cyc >= next_arb && bus.req != 0) begin
          for (int k = 3; k >= 0; k--)
            if (bus.req[(ptr + k) % 4]) win = (ptr + k) % 4;
          exp_gnt = 4'b0001 << win;
          lpend = 1'b1;
          next_arb = cyc + H + 2;
        end
      end
    end

    // Monitor: per-cycle state checks, ack-driven scoreboard pops, directed sequence checks.
    int k = 0, prev = 0;
    always @(negedge clk) begin
      exp_t e;
      if (m_rst) k = 0;
      chk("gnt", g, bus.gnt, exp_gnt);
      chk("q", g, bus.q, exp_q);
      chk("q_owner", g, bus.q_owner, exp_own);
      chk("q_valid", g, bus.q_valid, exp_qv);
      if (bus.ack != 0) begin
        if (sbq.size() == 0) chk("unexpected_ack", g, bus.ack, 0);
        else begin
          e = sbq.pop_front();
          chk("ack_idx", g, bus.ack, 4'b0001 << e.idx);
          chk("ack_data", g, bus.q, e.data);
        end
        case (mode)
          M_SINGLE: if (k == 0) begin
            chk("single_q", g, bus.q, 8'hA5);
            chk("single_owner", g, bus.q_owner, 2);
          end
          M_ALL: if (k < 5) begin
            chk("fair_owner", g, bus.q_owner, k % 4);
            chk("fair_q", g, bus.q, 8'h10 + k % 4);
            if (k > 0) chk("fair_gap", g, cyc - prev, H + 2);
          end
          M_WRAP: if (k < 4) chk("wrap_owner", g, bus.q_owner, (k % 2) ? 3 : 0);
          M_COMMIT: if (k == 0) begin
            chk("commit_q", g, bus.q, 8'h3C);
            chk("commit_ack", g, bus.ack, 4'b0010);
          end
          M_0011: if (k < 4) begin
            chk("alt_owner", g, bus.q_owner, k % 2);
            if (k > 0) chk("alt_gap", g, cyc - prev, H + 2);
          end
          default: ;
        endcase
        k++;
        prev = cyc;
      end else if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("missing_ack", g, bus.ack, 4'b0001 << e.idx);
      end
    end
  end

  task automatic run_mode(input mode_e m, input int n);
    @(negedge clk);
    rst  = 1'b1;
    mode = m;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit got;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    run_mode(M_SINGLE, 12);
    run_mode(M_ALL, 24);
    run_mode(M_WRAP, 20);
    run_mode(M_COMMIT, 10);
    run_mode(M_0011, 12);

    // Abort a load with reset; the next round must start again from requester 0.
    run_mode(M_SINGLE, 0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (gnt_w[0] != 0) got = 1'b1;
      else @(negedge clk);
    end
    n_total++;
    if (got) n_pass++;
    else $display("FAIL load_abort_grant_wait u0 got no grant in 20 cycles");
    rst  = 1'b1;
    mode = M_ALL;
    @(negedge clk);
    rst = 1'b0;
    repeat (24) @(negedge clk);

    run_mode(M_RAND, 300);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
